// File: rtl/cp0_register_file.sv
// -----------------------------------------------------------------------------
// cp0_register_file
//
// Architectural storage for coprocessor-0: SR (12), Cause (13), EPC (14) and
// the read-only PRId (15). Consumes the new_*/*_enable write pairs from the
// CP0 write-submission logic, feeds the stored values back to it and to the
// eret PC-select path, synchronises the external interrupt lines and serves
// the mfc0 read port.
//
// Ports:
//   clk               system clock, all state on rising edge
//   reset             asynchronous, active-high reset
//   hw_int[5:0]       raw external interrupt lines (asynchronous, level)
//   new_SR/SR_enable        SR write value and strobe
//   new_Cause/Cause_enable  Cause write value and strobe
//   new_EPC/EPC_enable      EPC write value and strobe
//   read_address[4:0] mfc0 source register number
//   read_data[31:0]   mfc0 result (combinational, pre-edge value)
//   current_SR/Cause/EPC    stored register values
//   interrupt_request[5:0]  synchronised hw_int (Cause/SR bits 15:10)
//   handler_address   constant exception-handler entry PC
//   exl_active        SR.EXL
// -----------------------------------------------------------------------------
module cp0_register_file #(
   parameter logic [31:0] PRID_VALUE      = 32'h5A5A0001,
   parameter logic [31:0] HANDLER_ADDRESS = 32'h00004180
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  hw_int,
   input  logic [31:0] new_SR,
   input  logic        SR_enable,
   input  logic [31:0] new_Cause,
   input  logic        Cause_enable,
   input  logic [31:0] new_EPC,
   input  logic        EPC_enable,
   input  logic [4:0]  read_address,
   output logic [31:0] read_data,
   output logic [31:0] current_SR,
   output logic [31:0] current_Cause,
   output logic [31:0] current_EPC,
   output logic [5:0]  interrupt_request,
   output logic [31:0] handler_address,
   output logic        exl_active
);

   localparam logic [4:0] ADDR_SR    = 5'd12;
   localparam logic [4:0] ADDR_CAUSE = 5'd13;
   localparam logic [4:0] ADDR_EPC   = 5'd14;
   localparam logic [4:0] ADDR_PRID  = 5'd15;

   // Only IM[15:10], EXL[1] and IE[0] are implemented in SR.
   function automatic logic [31:0] mask_sr(input logic [31:0] value);
      return value & 32'h0000FC03;
   endfunction

   // Only BD[31], IP[15:10] and ExcCode[6:2] are implemented in Cause.
   function automatic logic [31:0] mask_cause(input logic [31:0] value);
      return value & 32'h8000FC7C;
   endfunction

   // EPC always holds a word-aligned PC.
   function automatic logic [31:0] align_epc(input logic [31:0] value);
      return {value[31:2], 2'b00};
   endfunction

   logic [31:0] sr_q;
   logic [31:0] cause_q;
   logic [31:0] epc_q;
   logic [5:0]  sync_p0;
   logic [5:0]  sync_p1;

   // Architectural registers: each strobe is independent, no priority.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr_q    <= '0;
         cause_q <= '0;
         epc_q   <= '0;
      end else begin
         if (SR_enable)    sr_q    <= mask_sr(new_SR);
         if (Cause_enable) cause_q <= mask_cause(new_Cause);
         if (EPC_enable)   epc_q   <= align_epc(new_EPC);
      end
   end

   // Two-flop synchroniser per interrupt line; level follows the line.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= hw_int;
         sync_p1 <= sync_p0;
      end
   end

   // Read port sees stored state only; same-cycle writes are not forwarded.
   always_comb begin
      read_data = '0;
      case (read_address)
         ADDR_SR:    read_data = sr_q;
         ADDR_CAUSE: read_data = cause_q;
         ADDR_EPC:   read_data = epc_q;
         ADDR_PRID:  read_data = PRID_VALUE;
         default:    read_data = '0;
      endcase
   end

   assign current_SR        = sr_q;
   assign current_Cause     = cause_q;
   assign current_EPC       = epc_q;
   assign interrupt_request = sync_p1;
   assign handler_address   = HANDLER_ADDRESS;
   assign exl_active        = sr_q[1];

endmodule

// File: tb/tb_cp0_register_file.sv
module tb_cp0_register_file;

   localparam logic [31:0] PRID    = 32'h5A5A0001;
   localparam logic [31:0] HANDLER = 32'h00004180;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  hw_int;
   logic [31:0] new_SR, new_Cause, new_EPC;
   logic        SR_enable, Cause_enable, EPC_enable;
   logic [4:0]  read_address;
   logic [31:0] read_data, current_SR, current_Cause, current_EPC, handler_address;
   logic [5:0]  interrupt_request;
   logic        exl_active;

   cp0_register_file #(.PRID_VALUE(PRID), .HANDLER_ADDRESS(HANDLER)) dut (
      .clk(clk), .reset(reset), .hw_int(hw_int),
      .new_SR(new_SR), .SR_enable(SR_enable),
      .new_Cause(new_Cause), .Cause_enable(Cause_enable),
      .new_EPC(new_EPC), .EPC_enable(EPC_enable),
      .read_address(read_address), .read_data(read_data),
      .current_SR(current_SR), .current_Cause(current_Cause),
      .current_EPC(current_EPC), .interrupt_request(interrupt_request),
      .handler_address(handler_address), .exl_active(exl_active)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] sr;
      logic [31:0] cause;
      logic [31:0] epc;
      logic [31:0] rd;
      logic [5:0]  irq;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference state: architectural contents plus the hw_int values seen at
   // the last two rising edges since reset (interrupt_request is the older).
   logic [31:0] m_sr, m_cause, m_epc;
   logic [5:0]  m_seen[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [4:0] a);
      case (a)
         5'd12:   return m_sr;
         5'd13:   return m_cause;
         5'd14:   return m_epc;
         5'd15:   return PRID;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [5:0] m_irq();
      return m_seen[0];
   endfunction

   task automatic m_clear();
      m_sr = '0; m_cause = '0; m_epc = '0;
      m_seen = {6'd0, 6'd0};
   endtask

   // One clock of stimulus: drive on the falling edge, check the pre-edge
   // read, then queue what the DUT must show after the next rising edge.
   task automatic cycle(input logic rst, input logic [5:0] h,
                        input logic se, input logic [31:0] sv,
                        input logic ce, input logic [31:0] cv,
                        input logic ee, input logic [31:0] ev,
                        input logic [4:0] ra);
      exp_t e;
      @(negedge clk);
      reset = rst; hw_int = h;
      SR_enable = se; new_SR = sv;
      Cause_enable = ce; new_Cause = cv;
      EPC_enable = ee; new_EPC = ev;
      read_address = ra;
      if (rst) m_clear();
      #1;
      check("pre_edge_read", read_data, m_read(ra));
      if (!rst) begin
         if (se) m_sr    = sv & 32'h0000FC03;
         if (ce) m_cause = cv & 32'h8000FC7C;
         if (ee) m_epc   = ev & 32'hFFFFFFFC;
         m_seen.push_back(h);
         void'(m_seen.pop_front());
      end
      e.sr = m_sr; e.cause = m_cause; e.epc = m_epc;
      e.rd = m_read(ra); e.irq = m_irq();
      exp_q.push_back(e);
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   // Monitor: compares the DUT state after every rising edge that has an
   // expectation queued.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("sr",        current_SR,              e.sr);
         check("cause",     current_Cause,           e.cause);
         check("epc",       current_EPC,             e.epc);
         check("read_data", read_data,               e.rd);
         check("irq",       {26'd0, interrupt_request}, {26'd0, e.irq});
         check("exl",       {31'd0, exl_active},     {31'd0, e.sr[1]});
      end
   end

   initial begin
      logic [4:0] addrs [5];
      logic [31:0] vals [5];
      logic [5:0] h;
      logic [31:0] cv;
      addrs = '{5'd12, 5'd13, 5'd14, 5'd15, 5'd7};
      vals  = '{32'h0, 32'h0, 32'h0, PRID, 32'h0};

      reset = 1'b1; hw_int = '0;
      new_SR = '0; new_Cause = '0; new_EPC = '0;
      SR_enable = 0; Cause_enable = 0; EPC_enable = 0;
      read_address = 5'd12;
      m_clear();

      cycle(1, 6'd0, 0, 0, 0, 0, 0, 0, 5'd12);
      check("handler_address", handler_address, HANDLER);

      // Load nonzero state, then reset mid-cycle with writes pending.
      cycle(0, 6'd0, 1, 32'h0000FC03, 1, 32'h8000FC7C, 1, 32'h00001000, 5'd12);
      after_edge();
      check("sr_loaded", current_SR, 32'h0000FC03);
      @(negedge clk);
      #2;
      reset = 1'b1;
      SR_enable = 1; Cause_enable = 1; EPC_enable = 1;
      new_SR = 32'hFFFFFFFF; new_Cause = 32'hFFFFFFFF; new_EPC = 32'hFFFFFFFF;
      #1;
      check("rst_sr",    current_SR,    32'h0);
      check("rst_cause", current_Cause, 32'h0);
      check("rst_epc",   current_EPC,   32'h0);
      check("rst_irq",   {26'd0, interrupt_request}, 32'h0);
      for (int i = 0; i < 5; i++) begin
         read_address = addrs[i];
         #1;
         check("rst_readback", read_data, vals[i]);
      end
      m_clear();
      cycle(1, 6'd0, 1, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 5'd13);

      // SR masking.
      cycle(0, 6'd0, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 5'd12);
      after_edge();
      check("sr_mask", current_SR, 32'h0000FC03);
      check("sr_exl",  {31'd0, exl_active}, 32'd1);

      // Read during write returns the old value (pre-edge check in cycle).
      cycle(0, 6'd0, 1, 32'h00000401, 0, 0, 0, 0, 5'd12);
      after_edge();
      check("rdw_new", read_data, 32'h00000401);

      // Interrupt synchroniser with Cause IP fed back.
      for (int k = 0; k < 4; k++) begin
         cycle(0, 6'b000100, 0, 0, 1, {16'd0, m_irq(), 10'd0}, 0, 0, 5'd13);
         after_edge();
         if (k == 0) check("irq_1edge", {26'd0, interrupt_request}, 32'h0);
         if (k == 1) check("irq_2edge", {26'd0, interrupt_request}, 32'h4);
         if (k == 2) check("cause_ip12", {31'd0, current_Cause[12]}, 32'd1);
      end

      // Exception commit: all three strobes on one edge.
      cycle(0, 6'b000100, 1, 32'h00000003, 1, 32'hFFFFFFFF, 1, 32'h00003007, 5'd14);
      after_edge();
      check("exc_epc",   current_EPC,   32'h00003004);
      check("exc_cause", current_Cause, 32'h8000FC7C);
      check("exc_sr",    current_SR,    32'h00000003);

      // Reset during writes with all interrupt lines high.
      cycle(0, 6'b111111, 0, 0, 0, 0, 0, 0, 5'd12);
      cycle(1, 6'b111111, 1, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 5'd12);
      after_edge();
      check("rst_wr_sr",  current_SR,  32'h0);
      check("rst_wr_epc", current_EPC, 32'h0);
      cycle(0, 6'b111111, 0, 0, 0, 0, 0, 0, 5'd13);
      after_edge();
      check("irq_rel_1", {26'd0, interrupt_request}, 32'h0);
      cycle(0, 6'b111111, 0, 0, 0, 0, 0, 0, 5'd13);
      after_edge();
      check("irq_rel_2", {26'd0, interrupt_request}, 32'h3F);

      // Randomised traffic against the reference model.
      for (int n = 0; n < 400; n++) begin
         h  = 6'($urandom);
         cv = $urandom;
         if ($urandom_range(1, 0) == 1) cv[15:10] = m_irq();
         cycle(($urandom_range(39, 0) == 0), h,
               1'($urandom), $urandom,
               1'($urandom), cv,
               1'($urandom), $urandom,
               ($urandom_range(3, 0) == 0) ? 5'($urandom) : 5'($urandom_range(15, 12)));
      end

      repeat (3) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: actual %0d entries required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/cp0_register_file.md
Name: cp0_register_file

Overview:
- Architectural storage for coprocessor-0: SR (reg 12), Cause (reg 13), EPC (reg 14), PRId (reg 15).
- Sits directly downstream of the CP0 write-submission logic and consumes its new_*/*_enable pairs.
- Feeds current_SR, current_Cause and current_EPC back to that logic and to the PC-select path for eret.
- Synchronises the six external hardware interrupt lines into the interrupt_request vector that the submission logic consumes, and serves the mfc0 read port.

Parameters:
- PRID_VALUE, 32'h5A5A0001, read-only value returned for register 15.
- HANDLER_ADDRESS, 32'h00004180, constant exception-handler entry PC driven on handler_address.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- hw_int  input  6  raw external interrupt lines, asynchronous to clk, level-sensitive
- new_SR  input  32  SR write value
- SR_enable  input  1  SR write strobe
- new_Cause  input  32  Cause write value
- Cause_enable  input  1  Cause write strobe
- new_EPC  input  32  EPC write value
- EPC_enable  input  1  EPC write strobe
- read_address  input  5  mfc0 source register number
- read_data  output  32  mfc0 result
- current_SR  output  32  stored SR
- current_Cause  output  32  stored Cause
- current_EPC  output  32  stored EPC (eret target)
- interrupt_request  output  6  synchronised hw_int; maps to Cause/SR bits 15:10
- handler_address  output  32  HANDLER_ADDRESS
- exl_active  output  1  current_SR[1]

Behaviour:
- Reset (async, immediate):
  - SR, Cause and EPC go to 0.
  - Both synchroniser stages go to 0, so interrupt_request = 0.
  - read_data reflects the reset registers.
- Synchroniser:
  - Two flops per line: sync1 <= hw_int, sync2 <= sync1; interrupt_request = sync2.
  - Latency is exactly 2 rising edges from a stable hw_int change to interrupt_request. No edge detection; level follows the line.
- SR write masking (on rising edge when SR_enable = 1):
  - Store new_SR & 32'h0000FC03. Writable bits are IM[15:10], EXL[1] and IE[0]; all other bits read 0.
  - SR_enable = 0: hold.
- Cause write masking (on rising edge when Cause_enable = 1):
  - Store new_Cause & 32'h8000FC7C. Writable fields are BD[31], IP[15:10] and ExcCode[6:2].
  - Cause_enable = 0: hold.
  - Upstream asserts Cause_enable every cycle, so IP tracks interrupt_request with one extra cycle of lag.
- EPC:
  - On rising edge when EPC_enable = 1, store {new_EPC[31:2], 2'b00}. EPC is always word-aligned.
- Read port (combinational on read_address):
  - 12 returns SR, 13 returns Cause, 14 returns EPC, 15 returns PRID_VALUE; any other address returns 0.
  - Read in the same cycle as a write returns the pre-edge (old) value. No internal bypass; forwarding belongs to the pipeline.
- Simultaneous strobes: all three writes are independent and commit on the same edge; no priority is needed.
- Reset mid-operation: overrides pending writes in the same cycle and clears the synchroniser; any hw_int already asserted reappears 2 edges after reset deasserts.
- Outputs:
  - current_* and exl_active are register outputs, with no combinational path from the write inputs.
  - handler_address is constant.

Test Plan:
1. Reset and readback: assert reset mid-cycle with SR = 32'h0000FC03 → all current_* = 0 immediately, read_data = 0 at addresses 12/13/14, PRID_VALUE at address 15, 0 at address 7.
2. SR mask: SR_enable = 1, new_SR = 32'hFFFFFFFF → after edge current_SR = 32'h0000FC03, exl_active = 1.
3. Read-during-write: SR_enable = 1, new_SR = 32'h00000401, read_address = 12 → read_data shows the old value before the edge and 32'h00000401 after it.
4. Interrupt sync: hw_int goes from 0 to 6'b000100 → interrupt_request = 0 after 1 edge and 6'b000100 after 2 edges. With Cause_enable held at 1 and the IP field fed back, current_Cause[12] = 1 one edge later.
5. Exception commit: same-edge SR_enable, Cause_enable and EPC_enable with new_EPC = 32'h00003007 and new_Cause = 32'hFFFFFFFF → current_EPC = 32'h00003004, current_Cause = 32'h8000FC7C; the SR update lands on the same edge.
6. Async reset during writes: assert reset while all strobes are active → no write lands and all registers read 0; hw_int held at 6'b111111 → interrupt_request = 6'b111111 two edges after reset falls.
